cdc_handshake_tx: RTL and testbench

//  - Source (transmit) end of a 4-phase req/ack clock-domain crossing.
//  - Moves DATA_W-bit words (AES blocks) from the clk domain to a receiver in another domain.
//  - Holds tx_data stable while tx_req is high and until the handshake completes.
//  - Synchronizes the receiver's asynchronous tx_ack into clk through SYNC_STAGES flops.

---
 rtl/cdc_handshake_tx_pkg.sv | 12 +
 rtl/cdc_handshake_tx_if.sv | 31 +++
 rtl/cdc_handshake_tx_ack_sync.sv | 20 ++
 rtl/cdc_handshake_tx.sv | 122 ++++++++++++
 tb/tb_cdc_handshake_tx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_handshake_tx_pkg.sv
// Shared types and defaults for the 4-phase req/ack CDC transmitter.
package cdc_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } cdc_tx_state_t;

    localparam int CDC_TX_DATA_W_DEF = 128;

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// Bundle of upstream valid/ready, downstream req/ack and status signals of the CDC transmitter.
interface cdc_handshake_tx_if
    import cdc_tx_pkg::*;
#(
    parameter int DATA_W = CDC_TX_DATA_W_DEF
);

    // Upstream: a word moves when in_valid & in_ready are both 1 at a rising clk edge;
    // in_valid/in_data must not depend on in_ready. Downstream: tx_req rises with tx_data
    // stable, the receiver raises tx_ack, tx_req falls, the receiver drops tx_ack.
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx_req;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ack;
    logic              busy;
    logic              xfer_done;
    cdc_tx_state_t     fsm_state;

    modport master (
        input  in_valid, in_data, tx_ack,
        output in_ready, tx_req, tx_data, busy, xfer_done, fsm_state
    );

    modport slave (
        output in_valid, in_data, tx_ack,
        input  in_ready, tx_req, tx_data, busy, xfer_done, fsm_state
    );

endinterface

// File: rtl/cdc_handshake_tx_ack_sync.sv
// Multi-flop synchronizer bringing the receiver's asynchronous acknowledge into clk.
module cdc_tx_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic ack,
    output logic ack_s
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) ff <= '0;
        else        ff <= {ff[SYNC_STAGES-2:0], ack};
    end

    assign ack_s = ff[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Transmit end of a 4-phase req/ack clock-domain crossing for DATA_W-bit words.
// Optional one-entry skid buffer enabled by defining CDC_TX_SKID_EN.
module cdc_handshake_tx
    import cdc_tx_pkg::*;
#(
    parameter int DATA_W      = CDC_TX_DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               n_rst,
    cdc_handshake_tx_if.master bus
);

    logic              ack_s;
    cdc_tx_state_t     state;
    cdc_tx_state_t     next_state;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] launch_data;
    logic              tx_req_q;
    logic              xfer_done_q;
    logic              ready;
    logic              busy;
    logic              accept;
    logic              pending;
    logic              launch;

    cdc_tx_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .ack   (bus.tx_ack),
        .ack_s (ack_s)
    );

    assign accept = bus.in_valid & ready;

`ifdef CDC_TX_SKID_EN
    logic              skid_full;
    logic [DATA_W-1:0] skid_q;

    // A buffered word always goes out before a newly offered one.
    assign pending     = skid_full | accept;
    assign launch_data = skid_full ? skid_q : bus.in_data;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            skid_full <= 1'b0;
            skid_q    <= '0;
        end else if (launch && skid_full) begin
            skid_full <= 1'b0;
        end else if (accept && !launch) begin
            skid_full <= 1'b1;
            skid_q    <= bus.in_data;
        end
    end
`else
    assign pending     = accept;
    assign launch_data = bus.in_data;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    // A new word only launches once the previous ack has been seen low.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (!ack_s && pending) begin
                    next_state = REQ;
                    launch     = 1'b1;
                end
            end
            REQ: begin
                if (ack_s) next_state = DROP;
            end
            DROP: begin
                if (!ack_s) begin
                    if (pending) begin
                        next_state = REQ;
                        launch     = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
`ifdef CDC_TX_SKID_EN
        ready = !skid_full;
`else
        ready = (state == IDLE) && !ack_s;
`endif
    end

    // tx_req and xfer_done come straight from flops so the crossing sees no glitches.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q      <= '0;
            tx_req_q    <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            if (launch) data_q <= launch_data;
            tx_req_q    <= (next_state == REQ);
            xfer_done_q <= (state == DROP) && !ack_s;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.busy      = busy;
    assign bus.tx_req    = tx_req_q;
    assign bus.tx_data   = data_q;
    assign bus.xfer_done = xfer_done_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a behavioural receiver in a 3:7 clock domain.
module tb_cdc_handshake_tx;
    import cdc_tx_pkg::*;

    localparam int DATA_W      = 128;
    localparam int SYNC_STAGES = 2;
    localparam int RX_LAT      = 2;
`ifdef CDC_TX_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic clk     = 1'b0;
    logic rx_clk  = 1'b0;
    logic n_rst   = 1'b0;
    logic rx_en   = 1'b0;
    logic man_ack = 1'b0;
    logic rx_ack  = 1'b0;
    logic req_m   = 1'b0;
    logic req_s   = 1'b0;
    int   rx_cnt  = 0;

    logic [DATA_W-1:0] rx_got[$];
    logic [DATA_W-1:0] exp_q[$];
    int tests_run = 0;
    int fails     = 0;

    cdc_handshake_tx_if #(.DATA_W(DATA_W)) bus ();

    cdc_handshake_tx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    assign bus.tx_ack = rx_en ? rx_ack : man_ack;

    // ---------------- clock/reset block ----------------
    always #3 clk = ~clk;
    always #7 rx_clk = ~rx_clk;

    // Receiver: ack rises RX_LAT rx cycles after the synchronized req, falls after req falls.
    always @(posedge rx_clk) begin
        req_m <= bus.tx_req;
        req_s <= req_m;
        if (!rx_en) begin
            rx_ack <= 1'b0;
            rx_cnt <= 0;
        end else if (req_s && !rx_ack) begin
            if (rx_cnt == RX_LAT) begin
                rx_ack <= 1'b1;
                rx_cnt <= 0;
                rx_got.push_back(bus.tx_data);
            end else begin
                rx_cnt <= rx_cnt + 1;
            end
        end else if (!req_s && rx_ack) begin
            rx_ack <= 1'b0;
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        int cyc = 0;
        n_rst = 1'b0; rx_en = 1'b0; man_ack = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(negedge clk);
        tests_run++; if (bus.tx_req !== 1'b0) begin fails++; $display("FAIL reset_tx_req got=%b exp=0", bus.tx_req); end
        tests_run++; if (bus.tx_data !== '0) begin fails++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
        tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tests_run++; if (bus.xfer_done !== 1'b0) begin fails++; $display("FAIL reset_xfer_done got=%b exp=0", bus.xfer_done); end
        tests_run++; if (bus.fsm_state !== IDLE) begin fails++; $display("FAIL reset_state got=%0d exp=%0d", bus.fsm_state, IDLE); end
        @(posedge clk); #1 n_rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (bus.in_ready !== SKID) begin fails++; $display("FAIL reset_ack_high_ready got=%b exp=%b", bus.in_ready, SKID); end
        tests_run++; if (bus.tx_req !== 1'b0) begin fails++; $display("FAIL reset_ack_high_req got=%b exp=0", bus.tx_req); end
        @(posedge clk); #1 man_ack = 1'b0;
        while (bus.in_ready !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_ack_low_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_single_word();
        logic [DATA_W-1:0] w = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        int pulses = 0;
        int held_bad = 0;
        int cyc = 0;
        rx_got.delete();
        rx_en = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b1; bus.in_data = w;
        @(negedge clk);
        tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL single_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk); #1 bus.in_valid = 1'b0; bus.in_data = ~w;
        @(negedge clk);
        tests_run++; if (bus.tx_req !== 1'b1) begin fails++; $display("FAIL single_req_cycle1 got=%b exp=1", bus.tx_req); end
        tests_run++; if (bus.tx_data !== w) begin fails++; $display("FAIL single_data got=%h exp=%h", bus.tx_data, w); end
        tests_run++; if (bus.fsm_state !== REQ) begin fails++; $display("FAIL single_state got=%0d exp=%0d", bus.fsm_state, REQ); end
        while (pulses == 0 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (bus.tx_data !== w) held_bad++;
            if (bus.xfer_done === 1'b1) pulses++;
        end
        repeat (6) begin
            @(negedge clk);
            if (bus.tx_data !== w) held_bad++;
            if (bus.xfer_done === 1'b1) pulses++;
        end
        tests_run++; if (pulses != 1) begin fails++; $display("FAIL single_done_pulses got=%0d exp=1", pulses); end
        tests_run++; if (held_bad != 0) begin fails++; $display("FAIL single_data_held got=%0d changes exp=0", held_bad); end
        tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_idle_after got=%b exp=0", bus.busy); end
        tests_run++; if (rx_got.size() != 1 || rx_got[0] !== w) begin fails++; $display("FAIL single_rx got_n=%0d exp_n=1 exp=%h", rx_got.size(), w); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] words[4];
        int idx = 0;
        int pulses = 0;
        int viol = 0;
        int cyc = 0;
        logic prev_done = 1'b0;
        logic dbl = 1'b0;
        logic go;
        words[0] = 128'hA5A5A5A5_00000001_DEADBEEF_01234567;
        words[1] = 128'h5A5A5A5A_00000002_CAFEF00D_89ABCDEF;
        words[2] = 128'hFFFFFFFF_00000003_00000000_FFFFFFFF;
        words[3] = 128'h00000000_00000004_12345678_9ABCDEF0;
        rx_got.delete(); exp_q.delete();
        rx_en = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b1; bus.in_data = words[0];
        while ((idx < 4 || pulses < 4) && cyc < 3000) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.in_ready === 1'b1) viol++;
            if (bus.xfer_done === 1'b1) begin
                pulses++;
                if (prev_done) dbl = 1'b1;
            end
            prev_done = bus.xfer_done;
            go = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (go) begin
                exp_q.push_back(words[idx]);
                idx++;
                if (idx < 4) bus.in_data = words[idx];
                else bus.in_valid = 1'b0;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        tests_run++; if (idx != 4) begin fails++; $display("FAIL b2b_accepted got=%0d exp=4", idx); end
        tests_run++; if (pulses != 4) begin fails++; $display("FAIL b2b_done_pulses got=%0d exp=4", pulses); end
        tests_run++; if (dbl !== 1'b0) begin fails++; $display("FAIL b2b_done_back_to_back got=%b exp=0", dbl); end
`ifndef CDC_TX_SKID_EN
        tests_run++; if (viol != 0) begin fails++; $display("FAIL b2b_ready_while_busy got=%0d exp=0", viol); end
`endif
        tests_run++; if (rx_got.size() != 4) begin fails++; $display("FAIL b2b_rx_count got=%0d exp=4", rx_got.size()); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i >= rx_got.size() || i >= exp_q.size() || rx_got[i] !== exp_q[i]) begin
                fails++; $display("FAIL b2b_rx_word%0d got_n=%0d exp=%h", i, rx_got.size(), words[i]);
            end
        end
    endtask

    task automatic test_spurious_ack();
        int cyc = 0;
        int req_bad = 0;
        int state_bad = 0;
        rx_en = 1'b0; man_ack = 1'b0; bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1 man_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.tx_req !== 1'b0) req_bad++;
            if (bus.fsm_state !== IDLE) state_bad++;
            if (k >= 2) begin
                tests_run++;
                if (bus.in_ready !== SKID) begin fails++; $display("FAIL spurious_ready_k%0d got=%b exp=%b", k, bus.in_ready, SKID); end
            end
        end
        @(posedge clk); #1 man_ack = 1'b0;
        while (bus.in_ready !== 1'b1 && cyc < 10) begin
            @(negedge clk); cyc++;
            if (bus.tx_req !== 1'b0) req_bad++;
            if (bus.fsm_state !== IDLE) state_bad++;
        end
        tests_run++; if (req_bad != 0) begin fails++; $display("FAIL spurious_req got=%0d exp=0", req_bad); end
        tests_run++; if (state_bad != 0) begin fails++; $display("FAIL spurious_state got=%0d exp=0", state_bad); end
        tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL spurious_recover_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_reset_mid_req();
        logic [DATA_W-1:0] w1 = 128'h11111111_22222222_33333333_44444444;
        logic [DATA_W-1:0] w2 = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;
        int cyc = 0;
        rx_en = 1'b0; man_ack = 1'b0;
        @(posedge clk); #1 bus.in_valid = 1'b1; bus.in_data = w1;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.tx_req !== 1'b1) begin fails++; $display("FAIL midrst_req_before got=%b exp=1", bus.tx_req); end
        #1 n_rst = 1'b0;
        #1;
        tests_run++; if (bus.tx_req !== 1'b0) begin fails++; $display("FAIL midrst_req_async got=%b exp=0", bus.tx_req); end
        tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy_async got=%b exp=0", bus.busy); end
        @(posedge clk); @(posedge clk); #1 n_rst = 1'b1;
        @(negedge clk);
        tests_run++; if (bus.fsm_state !== IDLE) begin fails++; $display("FAIL midrst_state got=%0d exp=%0d", bus.fsm_state, IDLE); end
        tests_run++; if (bus.tx_data !== '0) begin fails++; $display("FAIL midrst_data got=%h exp=0", bus.tx_data); end
        rx_got.delete();
        rx_en = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b1; bus.in_data = w2;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        while (bus.xfer_done !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
        tests_run++; if (bus.xfer_done !== 1'b1) begin fails++; $display("FAIL midrst_new_done got=%b exp=1", bus.xfer_done); end
        tests_run++; if (rx_got.size() != 1 || rx_got[0] !== w2) begin fails++; $display("FAIL midrst_new_rx got_n=%0d exp=%h", rx_got.size(), w2); end
        tests_run++; if (bus.tx_data !== w2) begin fails++; $display("FAIL midrst_new_data got=%h exp=%h", bus.tx_data, w2); end
    endtask

`ifdef CDC_TX_SKID_EN
    task automatic test_skid();
        logic [DATA_W-1:0] a = 128'hAAAAAAAA_AAAAAAAA_00000000_0000000A;
        logic [DATA_W-1:0] b = 128'hBBBBBBBB_BBBBBBBB_00000000_0000000B;
        int gap = 0;
        int cyc = 0;
        int pulses = 0;
        rx_got.delete();
        rx_en = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b1; bus.in_data = a;
        @(posedge clk); #1 bus.in_data = b;
        @(negedge clk);
        tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL skid_ready_in_req got=%b exp=1", bus.in_ready); end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        while (bus.xfer_done !== 1'b1 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (bus.busy !== 1'b1) gap++;
        end
        tests_run++; if (bus.xfer_done !== 1'b1) begin fails++; $display("FAIL skid_first_done got=%b exp=1", bus.xfer_done); end
        tests_run++; if (bus.tx_data !== b) begin fails++; $display("FAIL skid_data_b got=%h exp=%h", bus.tx_data, b); end
        tests_run++; if (bus.tx_req !== 1'b1) begin fails++; $display("FAIL skid_req_b got=%b exp=1", bus.tx_req); end
        tests_run++; if (gap != 0) begin fails++; $display("FAIL skid_busy_gap got=%0d exp=0", gap); end
        cyc = 0;
        while (pulses == 0 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (bus.xfer_done === 1'b1) pulses++;
        end
        tests_run++; if (pulses != 1) begin fails++; $display("FAIL skid_second_done got=%0d exp=1", pulses); end
        tests_run++; if (rx_got.size() != 2 || rx_got[0] !== a || rx_got[1] !== b) begin
            fails++; $display("FAIL skid_rx_order got_n=%0d exp=%h,%h", rx_got.size(), a, b);
        end
    endtask
`endif

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_spurious_ack();
        test_reset_mid_req();
`ifdef CDC_TX_SKID_EN
        test_skid();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
